// File: rtl/axi_resp_pkg.sv
// rtl/axi_resp_pkg.sv - shared constants, state enums and helpers for the AXI memory responder
package axi_resp_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [2:0] SIZE_64 = 3'd3;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_DATA
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_e;

  // Anything other than full-width FIXED/INCR bursts is answered with SLVERR.
  function automatic logic xfer_error(input logic [2:0] size, input logic [1:0] burst);
    return (size != SIZE_64) || (burst == 2'b10) || (burst == 2'b11);
  endfunction

endpackage

// File: rtl/axi_mem_responder_if.sv
// rtl/axi_mem_responder_if.sv - AXI4 bus bundle between an initiator and the memory responder
interface axi_mem_responder_if;

  logic [5:0]  s_axi_awid;
  logic [31:0] s_axi_awaddr;
  logic [7:0]  s_axi_awlen;
  logic [2:0]  s_axi_awsize;
  logic [1:0]  s_axi_awburst;
  logic        s_axi_awvalid;
  logic        s_axi_awready;

  logic [63:0] s_axi_wdata;
  logic [7:0]  s_axi_wstrb;
  logic        s_axi_wlast;
  logic        s_axi_wvalid;
  logic        s_axi_wready;

  logic [5:0]  s_axi_bid;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;

  logic [5:0]  s_axi_arid;
  logic [31:0] s_axi_araddr;
  logic [7:0]  s_axi_arlen;
  logic [2:0]  s_axi_arsize;
  logic [1:0]  s_axi_arburst;
  logic        s_axi_arvalid;
  logic        s_axi_arready;

  logic [5:0]  s_axi_rid;
  logic [63:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast;
  logic        s_axi_rvalid;
  logic        s_axi_rready;

  modport slave (
    input  s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
    output s_axi_awready,
    input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    output s_axi_wready,
    output s_axi_bid, s_axi_bresp, s_axi_bvalid,
    input  s_axi_bready,
    input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
    output s_axi_arready,
    output s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
    input  s_axi_rready
  );

  modport master (
    output s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
    input  s_axi_awready,
    output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    input  s_axi_wready,
    input  s_axi_bid, s_axi_bresp, s_axi_bvalid,
    output s_axi_bready,
    output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
    input  s_axi_arready,
    input  s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
    output s_axi_rready
  );

endinterface

// File: rtl/axi_resp_mem.sv
// rtl/axi_resp_mem.sv - 64-bit word memory, byte-enabled write port and asynchronous read port
module axi_resp_mem #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wstrb,
  input  logic [63:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [63:0]   rdata
);

  logic [63:0] mem [0:(1 << AW) - 1];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 8; i++) begin
        if (wstrb[i]) begin
          mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Combinational read: a same-cycle write to this word is seen only after the edge.
  assign rdata = mem[raddr];

endmodule

// File: rtl/axi_mem_responder.sv
// rtl/axi_mem_responder.sv - AXI4 slave answering read and write bursts from an internal memory
module axi_mem_responder
  import axi_resp_pkg::*;
#(
  parameter int MEM_AW     = 10,
  parameter int RD_LATENCY = 2
) (
  input logic                clk,
  input logic                rst,
  axi_mem_responder_if.slave axi
);

  localparam logic [3:0] RD_CNT_INIT = 4'(RD_LATENCY - 1);

  logic live;
  logic out_en;

  rd_state_e         rd_state, rd_state_nxt;
  logic [5:0]        rd_id;
  logic [MEM_AW-1:0] rd_idx;
  logic [7:0]        rd_len;
  logic [7:0]        rd_beat;
  logic [3:0]        rd_cnt;
  logic              rd_err;
  logic              rd_fixed;
  logic              rd_last;
  logic              ar_hs, r_hs;
  logic              arready_int, rvalid_int;

  wr_state_e         wr_state, wr_state_nxt;
  logic [5:0]        wr_id;
  logic [MEM_AW-1:0] wr_idx;
  logic [7:0]        wr_len;
  logic [7:0]        wr_beat;
  logic              wr_cfg_err;
  logic              wr_last_err;
  logic              wr_fixed;
  logic              wr_last;
  logic              aw_hs, w_hs, b_hs;
  logic              awready_int, wready_int, bvalid_int;

  logic              mem_we;
  logic [63:0]       mem_rdata;
  logic              unused_addr_bits;

  // Outputs stay low through reset and the first cycle after it.
  always_ff @(posedge clk) begin
    if (rst) live <= 1'b0;
    else     live <= 1'b1;
  end

  assign out_en = live & ~rst;

  assign arready_int = out_en && (rd_state == R_IDLE);
  assign rvalid_int  = out_en && (rd_state == R_DATA);
  assign ar_hs       = axi.s_axi_arvalid && arready_int;
  assign r_hs        = rvalid_int && axi.s_axi_rready;
  assign rd_last     = (rd_beat == rd_len);

  always_ff @(posedge clk) begin
    if (rst) rd_state <= R_IDLE;
    else     rd_state <= rd_state_nxt;
  end

  always_comb begin
    rd_state_nxt = rd_state;
    case (rd_state)
      R_IDLE: if (ar_hs) rd_state_nxt = (RD_LATENCY == 1) ? R_DATA : R_WAIT;
      R_WAIT: if (rd_cnt == 4'd1) rd_state_nxt = R_DATA;
      R_DATA: if (r_hs && rd_last) rd_state_nxt = R_IDLE;
      default: rd_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_id    <= '0;
      rd_idx   <= '0;
      rd_len   <= '0;
      rd_beat  <= '0;
      rd_cnt   <= '0;
      rd_err   <= 1'b0;
      rd_fixed <= 1'b0;
    end else if (ar_hs) begin
      rd_id    <= axi.s_axi_arid;
      rd_idx   <= axi.s_axi_araddr[MEM_AW+2:3];
      rd_len   <= axi.s_axi_arlen;
      rd_beat  <= '0;
      rd_cnt   <= RD_CNT_INIT;
      rd_err   <= xfer_error(axi.s_axi_arsize, axi.s_axi_arburst);
      rd_fixed <= (axi.s_axi_arburst == BURST_FIXED);
    end else if (rd_state == R_WAIT) begin
      rd_cnt <= rd_cnt - 4'd1;
    end else if (r_hs) begin
      rd_beat <= rd_beat + 8'd1;
      if (!rd_fixed) rd_idx <= rd_idx + 1'b1;
    end
  end

  assign axi.s_axi_arready = arready_int;
  assign axi.s_axi_rvalid  = rvalid_int;
  assign axi.s_axi_rid     = rvalid_int ? rd_id : '0;
  assign axi.s_axi_rdata   = (rvalid_int && !rd_err) ? mem_rdata : '0;
  assign axi.s_axi_rresp   = (rvalid_int && rd_err) ? RESP_SLVERR : RESP_OKAY;
  assign axi.s_axi_rlast   = rvalid_int && rd_last;

  assign awready_int = out_en && (wr_state == W_IDLE);
  assign wready_int  = out_en && (wr_state == W_DATA);
  assign bvalid_int  = out_en && (wr_state == W_RESP);
  assign aw_hs       = axi.s_axi_awvalid && awready_int;
  assign w_hs        = axi.s_axi_wvalid && wready_int;
  assign b_hs        = bvalid_int && axi.s_axi_bready;
  assign wr_last     = (wr_beat == wr_len);

  always_ff @(posedge clk) begin
    if (rst) wr_state <= W_IDLE;
    else     wr_state <= wr_state_nxt;
  end

  // The beat count, not wlast, decides where the burst ends.
  always_comb begin
    wr_state_nxt = wr_state;
    case (wr_state)
      W_IDLE: if (aw_hs) wr_state_nxt = W_DATA;
      W_DATA: if (w_hs && wr_last) wr_state_nxt = W_RESP;
      W_RESP: if (b_hs) wr_state_nxt = W_IDLE;
      default: wr_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_id       <= '0;
      wr_idx      <= '0;
      wr_len      <= '0;
      wr_beat     <= '0;
      wr_cfg_err  <= 1'b0;
      wr_last_err <= 1'b0;
      wr_fixed    <= 1'b0;
    end else if (aw_hs) begin
      wr_id       <= axi.s_axi_awid;
      wr_idx      <= axi.s_axi_awaddr[MEM_AW+2:3];
      wr_len      <= axi.s_axi_awlen;
      wr_beat     <= '0;
      wr_cfg_err  <= xfer_error(axi.s_axi_awsize, axi.s_axi_awburst);
      wr_last_err <= 1'b0;
      wr_fixed    <= (axi.s_axi_awburst == BURST_FIXED);
    end else if (w_hs) begin
      wr_beat <= wr_beat + 8'd1;
      if (!wr_fixed) wr_idx <= wr_idx + 1'b1;
      if (axi.s_axi_wlast != wr_last) wr_last_err <= 1'b1;
    end
  end

  assign mem_we = w_hs && !wr_cfg_err;

  assign axi.s_axi_awready = awready_int;
  assign axi.s_axi_wready  = wready_int;
  assign axi.s_axi_bvalid  = bvalid_int;
  assign axi.s_axi_bid     = bvalid_int ? wr_id : '0;
  assign axi.s_axi_bresp   = (bvalid_int && (wr_cfg_err || wr_last_err)) ? RESP_SLVERR : RESP_OKAY;

  axi_resp_mem #(.AW(MEM_AW)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_idx),
    .wstrb (axi.s_axi_wstrb),
    .wdata (axi.s_axi_wdata),
    .raddr (rd_idx),
    .rdata (mem_rdata)
  );

  assign unused_addr_bits = ^{axi.s_axi_awaddr[31:MEM_AW+3], axi.s_axi_awaddr[2:0],
                              axi.s_axi_araddr[31:MEM_AW+3], axi.s_axi_araddr[2:0]};

endmodule
